pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: fetch-address generator with boot, run, flush and halt states.
// Drives pc, memory select and a registered fetch_valid to the fetch stage.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_target,
    input  logic        branch_to_ram,
    input  logic        halt,
    input  logic        resume,
    output logic [15:0] pc,
    output logic        execute_from_ram,
    output logic        fetch_valid,
    output logic [1:0]  state,
    output logic [15:0] retired_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        FLUSH  = 2'b10,
        HALTED = 2'b11
    } seq_state_t;

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic        ram_q;
    logic        ram_d;
    logic        valid_q;
    logic        valid_d;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        consume;

    // State, pc, memory select, valid flag and retire counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ram_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ram_q   <= ram_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; in RUN the priority is halt, branch, stall, advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ram_d   = ram_q;
        consume = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                    consume = 1'b1;
                end else if (branch) begin
                    state_d = FLUSH;
                    pc_d    = {branch_target[15:2], 2'b00};
                    ram_d   = branch_to_ram;
                    consume = 1'b1;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_STEP;
                    consume = 1'b1;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            HALTED: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        valid_d = (state_d == RUN);
        count_d = consume ? count_q + 16'd1 : count_q;
    end

    assign pc               = pc_q;
    assign execute_from_ram = ram_q;
    assign fetch_valid      = valid_q;
    assign state            = state_q;
    assign retired_count    = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors checked against a behavioural model
// every cycle, plus literal expectations that pin the model.
module tb_pc_sequencer;

    localparam logic [1:0] S_BOOT   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_FLUSH  = 2'b10;
    localparam logic [1:0] S_HALTED = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        branch_to_ram = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic        execute_from_ram;
    logic        fetch_valid;
    logic [1:0]  state;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_state;
    logic [15:0] m_pc;
    logic        m_ram;
    logic [15:0] m_cnt;
    logic [15:0] saved_cnt;

    pc_sequencer dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .branch(branch),
        .branch_target(branch_target),
        .branch_to_ram(branch_to_ram),
        .halt(halt),
        .resume(resume),
        .pc(pc),
        .execute_from_ram(execute_from_ram),
        .fetch_valid(fetch_valid),
        .state(state),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_BOOT;
        m_pc    = 16'h0000;
        m_ram   = 1'b0;
        m_cnt   = 16'h0000;
    endtask

    task automatic compare_model();
        chk("model_state", int'(state), int'(m_state));
        chk("model_pc", int'(pc), int'(m_pc));
        chk("model_ram", int'(execute_from_ram), int'(m_ram));
        chk("model_valid", int'(fetch_valid), (m_state == S_RUN) ? 1 : 0);
        chk("model_retired", int'(retired_count), int'(m_cnt));
    endtask

    task automatic model_edge();
        if (m_state == S_BOOT) begin
            m_state = S_RUN;
        end else if (m_state == S_FLUSH) begin
            m_state = S_RUN;
        end else if (m_state == S_HALTED) begin
            if (resume) m_state = S_RUN;
        end else if (halt) begin
            m_state = S_HALTED;
            m_cnt   = m_cnt + 16'd1;
        end else if (branch) begin
            m_state = S_FLUSH;
            m_pc    = branch_target & 16'hFFFC;
            m_ram   = branch_to_ram;
            m_cnt   = m_cnt + 16'd1;
        end else if (!stall) begin
            m_pc  = m_pc + 16'd4;
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic step(input logic st, input logic br, input logic [15:0] tgt,
                        input logic bram, input logic h, input logic res);
        stall         = st;
        branch        = br;
        branch_target = tgt;
        branch_to_ram = bram;
        halt          = h;
        resume        = res;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic adv();
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_state", int'(state), 0);
        chk("reset_pc", int'(pc), 0);
        chk("reset_valid", int'(fetch_valid), 0);
        chk("reset_retired", int'(retired_count), 0);
        compare_model();
        @(negedge clk);
        reset = 1'b0;

        adv();
        chk("boot_state", int'(state), 1);
        chk("boot_pc", int'(pc), 16'h0000);
        chk("boot_valid", int'(fetch_valid), 1);
        adv();
        chk("run1_pc", int'(pc), 16'h0004);
        adv();
        chk("run2_pc", int'(pc), 16'h0008);
        chk("run2_retired", int'(retired_count), 2);

        for (int i = 0; i < 15; i++) adv();
        chk("pre_branch_pc", int'(pc), 16'h0044);
        step(1'b0, 1'b1, 16'h0103, 1'b1, 1'b0, 1'b0);
        chk("branch_pc", int'(pc), 16'h0100);
        chk("branch_ram", int'(execute_from_ram), 1);
        chk("branch_state", int'(state), 2);
        chk("branch_valid", int'(fetch_valid), 0);
        step(1'b1, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b0);
        chk("flush_exit_state", int'(state), 1);
        chk("flush_exit_pc", int'(pc), 16'h0100);

        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        adv();
        chk("stall_start_pc", int'(pc), 16'h0010);
        saved_cnt = retired_count;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("stall_pc", int'(pc), 16'h0010);
        chk("stall_retired", int'(retired_count), int'(saved_cnt));
        step(1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        chk("stall_branch_pc", int'(pc), 16'hFFFC);
        chk("stall_branch_state", int'(state), 2);
        chk("stall_branch_retired", int'(retired_count), int'(saved_cnt) + 1);
        adv();
        adv();
        chk("wrap_pc", int'(pc), 16'h0000);
        chk("wrap_ram", int'(execute_from_ram), 1);

        adv();
        step(1'b0, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b0);
        chk("halt_state", int'(state), 3);
        chk("halt_pc", int'(pc), 16'h0004);
        chk("halt_ram", int'(execute_from_ram), 1);
        step(1'b0, 1'b1, 16'h0400, 1'b0, 1'b1, 1'b0);
        adv();
        chk("halted_ignore_pc", int'(pc), 16'h0004);
        chk("halted_ignore_state", int'(state), 3);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("resume_state", int'(state), 1);
        adv();
        chk("resume_pc", int'(pc), 16'h0008);

        step(1'b0, 1'b1, 16'h0500, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_state", int'(state), 2);
        #3;
        reset = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_pc", int'(pc), 0);
        chk("async_ram", int'(execute_from_ram), 0);
        chk("async_valid", int'(fetch_valid), 0);
        chk("async_retired", int'(retired_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_model();
        @(negedge clk);
        reset = 1'b0;
        adv();
        chk("post_reset_state", int'(state), 1);
        chk("post_reset_pc", int'(pc), 0);
        adv();
        chk("post_reset_pc2", int'(pc), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
